// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS decode constants and multiply/divide unit types
// Purpose: opcode/function-code encodings used across the execute stage, plus the
//          HI/LO multiply/divide unit state type and iteration count.
// Ports:   none (package)
package mips_pkg;

    localparam logic [5:0] OPCODE_RTYPE = 6'h00;
    localparam logic [5:0] OPCODE_ADDI  = 6'h08;
    localparam logic [5:0] OPCODE_LW    = 6'h23;
    localparam logic [5:0] OPCODE_SW    = 6'h2B;

    localparam logic [5:0] FUNCT_SLL    = 6'h00;
    localparam logic [5:0] FUNCT_JR     = 6'h08;
    localparam logic [5:0] FUNCT_MFHI   = 6'h10;
    localparam logic [5:0] FUNCT_MTHI   = 6'h11;
    localparam logic [5:0] FUNCT_MFLO   = 6'h12;
    localparam logic [5:0] FUNCT_MTLO   = 6'h13;
    localparam logic [5:0] FUNCT_MULT   = 6'h18;
    localparam logic [5:0] FUNCT_MULTU  = 6'h19;
    localparam logic [5:0] FUNCT_DIV    = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU   = 6'h1B;
    localparam logic [5:0] FUNCT_ADD    = 6'h20;
    localparam logic [5:0] FUNCT_SUB    = 6'h22;
    localparam logic [5:0] FUNCT_AND    = 6'h24;
    localparam logic [5:0] FUNCT_OR     = 6'h25;
    localparam logic [5:0] FUNCT_SLT    = 6'h2A;

    localparam int MULDIV_ITER = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one iteration of shift-add multiply or restoring divide
// Purpose: combinational single step on a 2*DATA_W accumulator.
//   multiply: acc = {partial product, remaining multiplier bits}; add operand when
//             acc[0] is set, then shift right keeping the carry.
//   divide:   acc = {partial remainder, remaining dividend / quotient bits}; shift
//             left, subtract operand if it fits and shift in the quotient bit.
// Ports:
//   is_div   in  1         select restoring-divide step (else shift-add)
//   acc_in   in  2*DATA_W  accumulator before the step
//   operand  in  DATA_W    multiplicand or divisor magnitude
//   acc_out  out 2*DATA_W  accumulator after the step
module muldiv_step #(
    parameter int DATA_W = 32
) (
    input  logic                  is_div,
    input  logic [2*DATA_W-1:0]   acc_in,
    input  logic [DATA_W-1:0]     operand,
    output logic [2*DATA_W-1:0]   acc_out
);

    logic [DATA_W:0]   sum;
    logic [DATA_W:0]   trial;
    logic [DATA_W-1:0] addend;

    always_comb begin
        addend = acc_in[0] ? operand : {DATA_W{1'b0}};
        sum    = {1'b0, acc_in[2*DATA_W-1:DATA_W]} + {1'b0, addend};
        // Shifted remainder needs DATA_W+1 bits; bit DATA_W of the difference is the borrow.
        trial  = acc_in[2*DATA_W-1:DATA_W-1] - {1'b0, operand};
        if (is_div) begin
            if (!trial[DATA_W]) begin
                acc_out = {trial[DATA_W-1:0], acc_in[DATA_W-2:0], 1'b1};
            end else begin
                acc_out = {acc_in[2*DATA_W-2:0], 1'b0};
            end
        end else begin
            acc_out = {sum, acc_in[DATA_W-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle MIPS multiply/divide unit owning HI/LO
// Purpose: MULT/MULTU/DIV/DIVU/MTHI/MTLO beside the ALU; stalls the pipe via busy.
//   Optional macro MULDIV_SINGLE_CYCLE_MULT_EN: multiplies complete combinationally at
//   the accept edge; divides keep the iterative path.
// Ports:
//   clk     in  1       clock, rising edge
//   rst_n   in  1       asynchronous active-low reset
//   start   in  1       request valid, sampled only when busy==0
//   fncode  in  6       function code (FUNCT_*)
//   op_a    in  DATA_W  rs: multiplicand / dividend / MTHI-MTLO source
//   op_b    in  DATA_W  rt: multiplier / divisor
//   busy    out 1       operation in flight
//   done    out 1       one-cycle pulse when HI/LO first hold a new mul/div result
//   hi      out DATA_W  HI register
//   lo      out DATA_W  LO register
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int DATA_W = MULDIV_ITER
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [5:0]        fncode,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    muldiv_state_t state_q, state_d;

    logic [CNT_W-1:0]    cnt_q;
    logic [2*DATA_W-1:0] acc_q, acc_step;
    logic [DATA_W-1:0]   opb_q;
    logic                is_div_q, neg_q_q, neg_r_q, done_q;
    logic [DATA_W-1:0]   hi_q, lo_q;

    logic                accept, iter_op, is_signed, a_neg, b_neg;
    logic [DATA_W-1:0]   a_mag, b_mag;
    logic [2*DATA_W-1:0] prod_fix;
    logic [DATA_W-1:0]   quot_fix, rem_fix;

    assign accept    = start && (state_q == IDLE);
    assign is_signed = (fncode == FUNCT_MULT) || (fncode == FUNCT_DIV);
    assign a_neg     = is_signed && op_a[DATA_W-1];
    assign b_neg     = is_signed && op_b[DATA_W-1];
    assign a_mag     = a_neg ? -op_a : op_a;
    assign b_mag     = b_neg ? -op_b : op_b;

`ifdef MULDIV_SINGLE_CYCLE_MULT_EN
    logic [2*DATA_W-1:0] ext_a, ext_b, prod_1c;
    // Low 2*DATA_W bits of the product of sign-extended operands are the signed product.
    assign ext_a   = {{DATA_W{a_neg}}, op_a};
    assign ext_b   = {{DATA_W{b_neg}}, op_b};
    assign prod_1c = ext_a * ext_b;
    assign iter_op = accept && ((fncode == FUNCT_DIV) || (fncode == FUNCT_DIVU));
`else
    assign iter_op = accept && ((fncode == FUNCT_MULT) || (fncode == FUNCT_MULTU) ||
                                (fncode == FUNCT_DIV)  || (fncode == FUNCT_DIVU));
`endif

    muldiv_step #(.DATA_W(DATA_W)) u_step (
        .is_div  (is_div_q),
        .acc_in  (acc_q),
        .operand (opb_q),
        .acc_out (acc_step)
    );

    // Sign correction. A zero divisor leaves quotient magnitude all-ones and remainder
    // equal to |dividend|, so the same correction yields the required divide-by-zero values.
    assign prod_fix = neg_q_q ? -acc_q : acc_q;
    assign quot_fix = neg_q_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
    assign rem_fix  = neg_r_q ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (iter_op) state_d = RUN;
            RUN:     if (cnt_q == CNT_LAST) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            acc_q    <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        case (fncode)
                            FUNCT_MTHI: hi_q <= op_a;
                            FUNCT_MTLO: lo_q <= op_a;
`ifdef MULDIV_SINGLE_CYCLE_MULT_EN
                            FUNCT_MULT, FUNCT_MULTU: begin
                                {hi_q, lo_q} <= prod_1c;
                                done_q       <= 1'b1;
                            end
`endif
                            default: ;
                        endcase
                    end
                    if (iter_op) begin
                        acc_q    <= {{DATA_W{1'b0}}, a_mag};
                        opb_q    <= b_mag;
                        cnt_q    <= '0;
                        is_div_q <= (fncode == FUNCT_DIV) || (fncode == FUNCT_DIVU);
                        neg_q_q  <= a_neg ^ b_neg;
                        neg_r_q  <= a_neg;
                    end
                end
                RUN: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                FIX: begin
                    if (is_div_q) begin
                        {hi_q, lo_q} <= {rem_fix, quot_fix};
                    end else begin
                        {hi_q, lo_q} <= prod_fix;
                    end
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - directed self-checking bench for muldiv_unit
module tb_muldiv_unit;
    import mips_pkg::*;

`ifdef MULDIV_SINGLE_CYCLE_MULT_EN
    localparam int MUL_LAT = 0;
`else
    localparam int MUL_LAT = 33;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [5:0]  fncode = 6'h00;
    logic [31:0] op_a = 32'h0;
    logic [31:0] op_b = 32'h0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.DATA_W(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .fncode (fncode),
        .op_a   (op_a),
        .op_b   (op_b),
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    // Called at a falling edge; returns at the falling edge after the accept edge.
    task automatic issue(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
        start  = 1'b1;
        fncode = fn;
        op_a   = a;
        op_b   = b;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (hi !== 32'h0)   begin errors++; $display("FAIL reset_hi got %h want %h", hi, 32'h0); end
        checks++; if (lo !== 32'h0)   begin errors++; $display("FAIL reset_lo got %h want %h", lo, 32'h0); end
        checks++; if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0)  begin errors++; $display("FAIL reset_done got %b want 0", done); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_div();
        int seen;
        issue(FUNCT_MTHI, 32'h1111_2222, 32'h0);
        issue(FUNCT_MTLO, 32'h3333_4444, 32'h0);
        issue(FUNCT_DIVU, 32'd100, 32'd7);
        repeat (9) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL middiv_busy got %b want 1", busy); end
        rst_n = 1'b0;
        #1;
        checks++; if (hi !== 32'h0)  begin errors++; $display("FAIL middiv_rst_hi got %h want %h", hi, 32'h0); end
        checks++; if (lo !== 32'h0)  begin errors++; $display("FAIL middiv_rst_lo got %h want %h", lo, 32'h0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL middiv_rst_busy got %b want 0", busy); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++; if (seen !== 0) begin errors++; $display("FAIL middiv_no_done got %0d active cycles want 0", seen); end
    endtask

    task automatic test_mult();
        int lat;
        issue(FUNCT_MULT, 32'hFFFF_FFFE, 32'd3);
        wait_done(lat);
        checks++; if (lat !== MUL_LAT)     begin errors++; $display("FAIL mult_latency got %0d want %0d", lat, MUL_LAT); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi got %h want %h", hi, 32'hFFFF_FFFF); end
        checks++; if (lo !== 32'hFFFF_FFFA) begin errors++; $display("FAIL mult_lo got %h want %h", lo, 32'hFFFF_FFFA); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got %b want 0", done); end
    endtask

    task automatic test_div();
        int lat;
        issue(FUNCT_MTHI, 32'h55, 32'h0);
        issue(FUNCT_MTLO, 32'hAA, 32'h0);
        issue(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2);
        repeat (5) @(negedge clk);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL div_busy_run got %b want 1", busy); end
        checks++; if (hi !== 32'h55 || lo !== 32'hAA) begin
            errors++; $display("FAIL div_hold_hilo got %h/%h want %h/%h", hi, lo, 32'h55, 32'hAA);
        end
        wait_done(lat);
        checks++; if (lat + 5 !== 33)       begin errors++; $display("FAIL div_latency got %0d want 33", lat + 5); end
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo got %h want %h", lo, 32'hFFFF_FFFD); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi got %h want %h", hi, 32'hFFFF_FFFF); end
        @(negedge clk);
        issue(FUNCT_DIVU, 32'd100, 32'd7);
        wait_done(lat);
        checks++; if (lo !== 32'd14) begin errors++; $display("FAIL divu_lo got %h want %h", lo, 32'd14); end
        checks++; if (hi !== 32'd2)  begin errors++; $display("FAIL divu_hi got %h want %h", hi, 32'd2); end
        @(negedge clk);
    endtask

    task automatic test_div_edge();
        int lat;
        issue(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(lat);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_ovf_lo got %h want %h", lo, 32'h8000_0000); end
        checks++; if (hi !== 32'h0)         begin errors++; $display("FAIL div_ovf_hi got %h want %h", hi, 32'h0); end
        @(negedge clk);
        issue(FUNCT_DIVU, 32'd5, 32'd0);
        wait_done(lat);
        checks++; if (lat !== 33)           begin errors++; $display("FAIL divz_latency got %0d want 33", lat); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL divuz_lo got %h want %h", lo, 32'hFFFF_FFFF); end
        checks++; if (hi !== 32'd5)         begin errors++; $display("FAIL divuz_hi got %h want %h", hi, 32'd5); end
        @(negedge clk);
        issue(FUNCT_DIV, 32'hFFFF_FFF8, 32'd0);
        wait_done(lat);
        checks++; if (lo !== 32'h1)         begin errors++; $display("FAIL divz_neg_lo got %h want %h", lo, 32'h1); end
        checks++; if (hi !== 32'hFFFF_FFF8) begin errors++; $display("FAIL divz_neg_hi got %h want %h", hi, 32'hFFFF_FFF8); end
        @(negedge clk);
    endtask

    task automatic test_mthi_mtlo();
        int lat;
        issue(FUNCT_MTHI, 32'h77, 32'h0);
        issue(FUNCT_DIVU, 32'd100, 32'd7);
        repeat (3) @(negedge clk);
        issue(FUNCT_MTHI, 32'h1234, 32'h0);
        checks++; if (hi !== 32'h77) begin errors++; $display("FAIL mthi_busy_hi got %h want %h", hi, 32'h77); end
        wait_done(lat);
        checks++; if (lat + 4 !== 33) begin errors++; $display("FAIL mthi_busy_latency got %0d want 33", lat + 4); end
        checks++; if (hi !== 32'd2 || lo !== 32'd14) begin
            errors++; $display("FAIL mthi_busy_result got %h/%h want %h/%h", hi, lo, 32'd2, 32'd14);
        end
        @(negedge clk);
        issue(FUNCT_MTLO, 32'hABCD, 32'h0);
        checks++; if (lo !== 32'hABCD) begin errors++; $display("FAIL mtlo_lo got %h want %h", lo, 32'hABCD); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL mtlo_flags got busy=%b done=%b want 0/0", busy, done);
        end
        issue(FUNCT_ADD, 32'hDEAD_BEEF, 32'h1);
        checks++; if (busy !== 1'b0 || hi !== 32'd2 || lo !== 32'hABCD) begin
            errors++; $display("FAIL illegal_fn got busy=%b hi=%h lo=%h want 0/%h/%h", busy, hi, lo, 32'd2, 32'hABCD);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        issue(FUNCT_DIV, 32'd1000, 32'hFFFF_FFFD);
        wait_done(lat);
        checks++; if (lo !== 32'hFFFF_FEB3 || hi !== 32'd1) begin
            errors++; $display("FAIL b2b_first got %h/%h want %h/%h", hi, lo, 32'd1, 32'hFFFF_FEB3);
        end
        issue(FUNCT_DIVU, 32'hFFFF_FFFF, 32'h10);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b want 1", busy); end
        wait_done(lat);
        checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", lat); end
        checks++; if (lo !== 32'h0FFF_FFFF || hi !== 32'hF) begin
            errors++; $display("FAIL b2b_second got %h/%h want %h/%h", hi, lo, 32'hF, 32'h0FFF_FFFF);
        end
        @(negedge clk);
    endtask

    task automatic test_multu_cfg();
        int lat;
        issue(FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
`ifdef MULDIV_SINGLE_CYCLE_MULT_EN
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_1c_busy got %b want 0", busy); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL multu_1c_done got %b want 1", done); end
`endif
        wait_done(lat);
        checks++; if (lat !== MUL_LAT)     begin errors++; $display("FAIL multu_latency got %0d want %0d", lat, MUL_LAT); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi got %h want %h", hi, 32'hFFFF_FFFE); end
        checks++; if (lo !== 32'h1)         begin errors++; $display("FAIL multu_lo got %h want %h", lo, 32'h1); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_reset_mid_div();
        test_mult();
        test_div();
        test_div_edge();
        test_mthi_mtlo();
        test_back_to_back();
        test_multu_cfg();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
